// File: rtl/tpu_ctrl_pkg.sv
// rtl/tpu_ctrl_pkg.sv - shared state, command and VPU mode definitions for the tile sequencer
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

    localparam logic [2:0] VPU_BYPASS    = 3'd0;
    localparam logic [2:0] VPU_RELU      = 3'd1;
    localparam logic [2:0] VPU_BIAS      = 3'd2;
    localparam logic [2:0] VPU_BIAS_RELU = 3'd3;

    // Per-tile mode bits; widths of addresses, length and masks follow the instance parameters.
    typedef struct packed {
        logic       bias_en;
        logic [2:0] vpu_mode;
    } tile_cmd_t;

endpackage

// File: rtl/tpu_wb_tracker.sv
// rtl/tpu_wb_tracker.sv - counts result-row writebacks, forms the D address and watches the drain timeout
module tpu_wb_tracker #(
    parameter int ADDR_WIDTH    = 10,
    parameter int M_WIDTH       = 10,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  active,
    input  logic                  drain,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] d_base,
    input  logic [M_WIDTH-1:0]    m_len,
    output logic [ADDR_WIDTH-1:0] wr_addr_d,
    output logic                  wb_complete,
    output logic                  timeout
);

    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    logic [M_WIDTH-1:0] wb_cnt;
    logic [TW-1:0]      idle_cnt;
    logic               wb_fire;

    assign wb_fire     = active && wb_valid;
    // Counts the writeback of this cycle so the FSM can leave DRAIN without an extra cycle.
    assign wb_complete = (wb_cnt + M_WIDTH'(wb_fire)) == m_len;
    assign timeout     = drain && !wb_fire && (idle_cnt == TW'(DRAIN_TIMEOUT - 1));
    assign wr_addr_d   = active ? d_base + ADDR_WIDTH'(wb_cnt) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_cnt   <= '0;
            idle_cnt <= '0;
        end else begin
            if (start) begin
                wb_cnt <= '0;
            end else if (wb_fire) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
            if (!drain || wb_fire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tpu_tile_sequencer.sv
// rtl/tpu_tile_sequencer.sv - tile command FSM driving weight load, input streaming and result drain
module tpu_tile_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int ADDR_WIDTH           = 10,
    parameter int M_WIDTH              = 10,
    parameter int DRAIN_TIMEOUT        = 256,
    localparam int IDX_WIDTH           = $clog2(SYSTOLIC_ARRAY_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [ADDR_WIDTH-1:0]           cmd_a_base,
    input  logic [ADDR_WIDTH-1:0]           cmd_b_base,
    input  logic [ADDR_WIDTH-1:0]           cmd_c_base,
    input  logic [ADDR_WIDTH-1:0]           cmd_d_base,
    input  logic [M_WIDTH-1:0]              cmd_m_len,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0] cmd_row_mask,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0] cmd_col_mask,
    input  logic [2:0]                      cmd_vpu_mode,
    input  logic                            cmd_bias_en,
    input  logic                            abort,
    output logic [ADDR_WIDTH-1:0]           ctrl_rd_addr_a,
    output logic                            ctrl_rd_en_a,
    output logic                            ctrl_a_valid,
    output logic                            ctrl_a_switch,
    output logic                            ctrl_psum_valid,
    output logic [ADDR_WIDTH-1:0]           ctrl_rd_addr_b,
    output logic                            ctrl_rd_en_b,
    output logic                            ctrl_b_accept_w,
    output logic [IDX_WIDTH-1:0]            ctrl_b_weight_index,
    output logic [ADDR_WIDTH-1:0]           ctrl_rd_addr_c,
    output logic                            ctrl_rd_en_c,
    output logic                            ctrl_c_valid,
    output logic [2:0]                      ctrl_vpu_mode,
    output logic [ADDR_WIDTH-1:0]           ctrl_wr_addr_d,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0] ctrl_row_mask,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0] ctrl_col_mask,
    input  logic                            core_writeback_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    seq_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]           a_base_q, b_base_q, c_base_q, d_base_q;
    logic [M_WIDTH-1:0]              m_len_q, m_cnt;
    logic [SYSTOLIC_ARRAY_WIDTH-1:0] row_mask_q, col_mask_q;
    tile_cmd_t                       cmd_q;
    logic [IDX_WIDTH-1:0]            w_cnt, widx_q;
    logic accept, bad, rd_en_a, rd_en_b, rd_en_c;
    logic a_valid_q, a_switch_q, c_valid_q, b_accept_q;
    logic wb_complete, timeout;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready && !abort;
    assign bad       = (m_len_q == '0) || (col_mask_q == '0);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            a_base_q   <= '0;
            b_base_q   <= '0;
            c_base_q   <= '0;
            d_base_q   <= '0;
            m_len_q    <= '0;
            row_mask_q <= '0;
            col_mask_q <= '0;
            cmd_q      <= '0;
            w_cnt      <= '0;
            m_cnt      <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_base_q   <= cmd_a_base;
                b_base_q   <= cmd_b_base;
                c_base_q   <= cmd_c_base;
                d_base_q   <= cmd_d_base;
                m_len_q    <= cmd_m_len;
                row_mask_q <= cmd_row_mask;
                col_mask_q <= cmd_col_mask;
                cmd_q      <= '{bias_en: cmd_bias_en, vpu_mode: cmd_vpu_mode};
                w_cnt      <= '0;
                m_cnt      <= '0;
                // A degenerate tile is flagged at accept; the sticky bit also clears here.
                err        <= (cmd_m_len == '0) || (cmd_col_mask == '0);
            end else begin
                if (rd_en_b) w_cnt <= w_cnt + 1'b1;
                if (rd_en_a) m_cnt <= m_cnt + 1'b1;
                if (state == DRAIN && timeout && !wb_complete && !abort) err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en_a   = 1'b0;
        rd_en_b   = 1'b0;
        rd_en_c   = 1'b0;
        case (state)
            IDLE:   if (accept) state_nxt = LOAD_W;
            LOAD_W: begin
                if (bad) begin
                    state_nxt = DONE;
                end else begin
                    rd_en_b = 1'b1;
                    if (w_cnt == IDX_WIDTH'(SYSTOLIC_ARRAY_WIDTH - 1)) state_nxt = STREAM;
                end
            end
            STREAM: begin
                rd_en_a = 1'b1;
                rd_en_c = cmd_q.bias_en;
                if (m_cnt == m_len_q - M_WIDTH'(1)) state_nxt = DRAIN;
            end
            DRAIN:  if (wb_complete || timeout) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Core buffers return data one cycle after the read, so valids trail the read strobes by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_q  <= 1'b0;
            a_switch_q <= 1'b0;
            c_valid_q  <= 1'b0;
            b_accept_q <= 1'b0;
            widx_q     <= '0;
        end else if (abort) begin
            a_valid_q  <= 1'b0;
            a_switch_q <= 1'b0;
            c_valid_q  <= 1'b0;
            b_accept_q <= 1'b0;
            widx_q     <= '0;
        end else begin
            a_valid_q  <= rd_en_a;
            a_switch_q <= rd_en_a && (m_cnt == '0);
            c_valid_q  <= rd_en_c;
            b_accept_q <= rd_en_b;
            widx_q     <= rd_en_b ? w_cnt : '0;
        end
    end

    tpu_wb_tracker #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .M_WIDTH       (M_WIDTH),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_wb_tracker (
        .clk         (clk),
        .rst         (rst),
        .start       (accept),
        .active      ((state == STREAM) || (state == DRAIN)),
        .drain       (state == DRAIN),
        .wb_valid    (core_writeback_valid),
        .d_base      (d_base_q),
        .m_len       (m_len_q),
        .wr_addr_d   (ctrl_wr_addr_d),
        .wb_complete (wb_complete),
        .timeout     (timeout)
    );

    assign ctrl_rd_en_a        = rd_en_a;
    assign ctrl_rd_addr_a      = rd_en_a ? a_base_q + ADDR_WIDTH'(m_cnt) : '0;
    assign ctrl_rd_en_b        = rd_en_b;
    assign ctrl_rd_addr_b      = rd_en_b ? b_base_q + ADDR_WIDTH'(w_cnt) : '0;
    assign ctrl_rd_en_c        = rd_en_c;
    assign ctrl_rd_addr_c      = rd_en_c ? c_base_q + ADDR_WIDTH'(m_cnt) : '0;
    assign ctrl_a_valid        = a_valid_q;
    assign ctrl_psum_valid     = a_valid_q;
    assign ctrl_a_switch       = a_switch_q;
    assign ctrl_c_valid        = c_valid_q;
    assign ctrl_b_accept_w     = b_accept_q;
    assign ctrl_b_weight_index = widx_q;
    assign ctrl_vpu_mode       = busy ? cmd_q.vpu_mode : '0;
    assign ctrl_row_mask       = busy ? row_mask_q : '0;
    assign ctrl_col_mask       = busy ? col_mask_q : '0;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb/tb_tpu_tile_sequencer.sv - randomized self-checking bench for tpu_tile_sequencer
module tb_tpu_tile_sequencer;
    import tpu_ctrl_pkg::*;

    localparam int W   = 4;
    localparam int AW  = 10;
    localparam int MW  = 10;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid, cmd_ready, cmd_bias_en, abort, core_writeback_valid;
    logic [AW-1:0] cmd_a_base, cmd_b_base, cmd_c_base, cmd_d_base;
    logic [MW-1:0] cmd_m_len;
    logic [W-1:0] cmd_row_mask, cmd_col_mask, ctrl_row_mask, ctrl_col_mask;
    logic [2:0] cmd_vpu_mode, ctrl_vpu_mode;
    logic [AW-1:0] ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c, ctrl_wr_addr_d;
    logic ctrl_rd_en_a, ctrl_a_valid, ctrl_a_switch, ctrl_psum_valid;
    logic ctrl_rd_en_b, ctrl_b_accept_w, ctrl_rd_en_c, ctrl_c_valid;
    logic [1:0] ctrl_b_weight_index;
    logic busy, done, err;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tpu_tile_sequencer #(
        .SYSTOLIC_ARRAY_WIDTH (W),
        .ADDR_WIDTH           (AW),
        .M_WIDTH              (MW),
        .DRAIN_TIMEOUT        (TMO)
    ) dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_a_base (cmd_a_base), .cmd_b_base (cmd_b_base),
        .cmd_c_base (cmd_c_base), .cmd_d_base (cmd_d_base),
        .cmd_m_len (cmd_m_len), .cmd_row_mask (cmd_row_mask), .cmd_col_mask (cmd_col_mask),
        .cmd_vpu_mode (cmd_vpu_mode), .cmd_bias_en (cmd_bias_en), .abort (abort),
        .ctrl_rd_addr_a (ctrl_rd_addr_a), .ctrl_rd_en_a (ctrl_rd_en_a),
        .ctrl_a_valid (ctrl_a_valid), .ctrl_a_switch (ctrl_a_switch),
        .ctrl_psum_valid (ctrl_psum_valid),
        .ctrl_rd_addr_b (ctrl_rd_addr_b), .ctrl_rd_en_b (ctrl_rd_en_b),
        .ctrl_b_accept_w (ctrl_b_accept_w), .ctrl_b_weight_index (ctrl_b_weight_index),
        .ctrl_rd_addr_c (ctrl_rd_addr_c), .ctrl_rd_en_c (ctrl_rd_en_c),
        .ctrl_c_valid (ctrl_c_valid), .ctrl_vpu_mode (ctrl_vpu_mode),
        .ctrl_wr_addr_d (ctrl_wr_addr_d), .ctrl_row_mask (ctrl_row_mask),
        .ctrl_col_mask (ctrl_col_mask), .core_writeback_valid (core_writeback_valid),
        .busy (busy), .done (done), .err (err)
    );

    task automatic check(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    // k counts cycles after the accept edge; expectations follow the documented phase timing:
    // reads of B at k=1..W, A/C at k=W+1..W+M, valids one cycle later, done one cycle after the last writeback.
    task automatic run_cmd(input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [AW-1:0] cb,
                           input logic [AW-1:0] db, input int m, input logic [W-1:0] rm,
                           input logic [W-1:0] cm, input logic [2:0] vm, input logic be,
                           input int gap_max, input int abort_k);
        logic bad, exp_err, rdb, accw, rda, av;
        logic [AW-1:0] ea;
        int done_k, wb_seen, next_wb, k;
        bit fin;
        bad     = (m == 0) || (cm == '0);
        done_k  = bad ? 2 : ((gap_max < 0) ? W + m + 1 + TMO : -1);
        exp_err = bad || (gap_max < 0);
        wb_seen = 0;
        next_wb = W + 3;
        fin     = 0;
        check("cmd_ready_idle", 0, cmd_ready, 1);
        cmd_valid = 1; cmd_a_base = ab; cmd_b_base = bb; cmd_c_base = cb; cmd_d_base = db;
        cmd_m_len = MW'(m); cmd_row_mask = rm; cmd_col_mask = cm; cmd_vpu_mode = vm; cmd_bias_en = be;
        @(negedge clk);
        cmd_valid = 0;
        for (k = 1; k < 300 && !fin; k++) begin
            core_writeback_valid = 0;
            abort = 0;
            if (abort_k > 0 && k > abort_k) begin
                check("abort_idle", k, {busy, done, ctrl_rd_en_a, ctrl_rd_en_b, ctrl_rd_en_c, ctrl_a_valid,
                      ctrl_psum_valid, ctrl_c_valid, ctrl_b_accept_w, cmd_ready, err}, 11'b00000000010);
                fin = (k == abort_k + 4);
            end else begin
                rdb  = !bad && k >= 1 && k <= W;
                accw = !bad && k >= 2 && k <= W + 1;
                rda  = !bad && k >= W + 1 && k <= W + m;
                av   = !bad && k >= W + 2 && k <= W + m + 1;
                check("rd_en_b", k, ctrl_rd_en_b, rdb);
                if (rdb) begin ea = bb + AW'(k - 1); check("rd_addr_b", k, ctrl_rd_addr_b, ea); end
                check("accept_w", k, ctrl_b_accept_w, accw);
                if (accw) check("weight_index", k, ctrl_b_weight_index, k - 2);
                check("rd_en_a", k, ctrl_rd_en_a, rda);
                check("rd_en_c", k, ctrl_rd_en_c, rda && be);
                if (rda) begin
                    ea = ab + AW'(k - W - 1); check("rd_addr_a", k, ctrl_rd_addr_a, ea);
                    if (be) begin ea = cb + AW'(k - W - 1); check("rd_addr_c", k, ctrl_rd_addr_c, ea); end
                end
                check("valids", k, {ctrl_a_valid, ctrl_psum_valid, ctrl_c_valid, ctrl_a_switch},
                      {av, av, av && be, av && (k == W + 2)});
                check("done", k, done, k == done_k);
                check("busy", k, busy, done_k < 0 || k <= done_k);
                if (!bad || k >= done_k)
                    check("err", k, err, (done_k > 0 && k >= done_k) ? exp_err : 1'b0);
                if (done_k < 0 || k <= done_k)
                    check("masks_mode", k, {ctrl_row_mask, ctrl_col_mask, ctrl_vpu_mode}, {rm, cm, vm});
                if (done_k > 0 && k == done_k + 1) begin
                    check("cmd_ready_after", k, cmd_ready, 1);
                    fin = 1;
                end else if (!bad && k == 2) begin
                    core_writeback_valid = 1;
                end else if (gap_max >= 0 && wb_seen < m && k >= next_wb) begin
                    ea = db + AW'(wb_seen);
                    check("wr_addr_d", k, ctrl_wr_addr_d, ea);
                    core_writeback_valid = 1;
                    wb_seen++;
                    next_wb = k + 1 + int'($urandom_range(0, gap_max));
                    if (wb_seen == m) done_k = k + 1;
                end
            end
            if (!fin) begin
                abort = (k == abort_k);
                @(negedge clk);
            end
        end
        check("finished", k, fin, 1);
        core_writeback_valid = 0;
        abort = 0;
    endtask

    initial begin
        cmd_valid = 0; abort = 0; core_writeback_valid = 0; cmd_bias_en = 0;
        cmd_a_base = '0; cmd_b_base = '0; cmd_c_base = '0; cmd_d_base = '0;
        cmd_m_len = '0; cmd_row_mask = '0; cmd_col_mask = '0; cmd_vpu_mode = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", 0, cmd_ready, 1);
        check("reset_outs", 0, {busy, done, err, ctrl_rd_en_a, ctrl_rd_en_b, ctrl_rd_en_c, ctrl_a_valid,
              ctrl_a_switch, ctrl_psum_valid, ctrl_b_accept_w, ctrl_c_valid, ctrl_wr_addr_d,
              ctrl_rd_addr_b, ctrl_row_mask, ctrl_vpu_mode}, 0);
        rst = 1;
        @(negedge clk);

        run_cmd(10'h100, 10'h010, 10'h200, 10'h3FE, 3, 4'hF, 4'hF, VPU_RELU, 1'b1, 2, 0);
        run_cmd(10'h055, 10'h066, 10'h077, 10'h088, 0, 4'h3, 4'hC, VPU_BIAS, 1'b1, 1, 0);
        run_cmd(10'h0A0, 10'h0B0, 10'h0C0, 10'h0D0, 2, 4'h5, 4'h0, VPU_BYPASS, 1'b0, 1, 0);
        run_cmd(10'h1F0, 10'h3FD, 10'h2F0, 10'h000, 2, 4'h9, 4'h6, VPU_BIAS_RELU, 1'b0, -1, 0);
        @(negedge clk);
        check("err_sticky", 0, err, 1);
        run_cmd(10'h300, 10'h020, 10'h310, 10'h320, 3, 4'hF, 4'h7, VPU_RELU, 1'b1, 1, W + 2);

        for (int i = 0; i < 8; i++) begin
            run_cmd(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
                    AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
                    int'($urandom_range(1, 6)), W'($urandom_range(1, 15)), W'($urandom_range(1, 15)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
        end

        cmd_valid = 1; cmd_m_len = MW'(2); cmd_col_mask = 4'hF; cmd_row_mask = 4'hF; cmd_b_base = 10'h040;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("pre_reset_rd_en_b", 2, ctrl_rd_en_b, 1);
        #1 rst = 0;
        #1;
        check("async_reset_outs", 2, {busy, done, ctrl_rd_en_b, ctrl_b_accept_w, ctrl_rd_addr_b,
              ctrl_row_mask, err}, 0);
        check("async_reset_ready", 2, cmd_ready, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("release_ready", 0, {cmd_ready, busy}, 2'b10);
        run_cmd(10'h123, 10'h234, 10'h345, 10'h3FF, 4, 4'hA, 4'h5, VPU_RELU, 1'b1, 3, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
